// File: rtl/ddr_line_responder_pkg.sv
// Shared sizing and FSM state encoding for the cache-line DDR responder.
package ddr_line_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int BEATS  = LINE_W / WORD_W;
  localparam int BEAT_W = $clog2(BEATS);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RESP,
    S_GAP
  } state_t;

endpackage

// File: rtl/ddr_line_responder_line_assembler.sv
// Collects read beats into a full line. o_line already reflects a word written
// this cycle, so the final beat and the line capture can share one edge.
module ddr_line_responder_line_assembler
  import ddr_line_responder_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [BEAT_W-1:0] i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_line
);

  logic [WORD_W-1:0] r_words [BEATS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BEATS; i++) r_words[i] <= '0;
    end else if (i_we) begin
      r_words[i_idx] <= i_wdata;
    end
  end

  always_comb begin
    o_line = '0;
    for (int i = 0; i < BEATS; i++) begin
      o_line[i*WORD_W +: WORD_W] = (i_we && (i_idx == BEAT_W'(i))) ? i_wdata : r_words[i];
    end
  end

endmodule

// File: rtl/ddr_line_responder.sv
// Serves 256-bit cache line loads/write-backs as 8 word beats on a 32-bit port.
// Write done ~9 cycles, load ~17 cycles with free grant; stalls on mem_gnt/mem_rvalid.
module ddr_line_responder
  import ddr_line_responder_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ram_en,
  input  logic              i_ram_write,
  input  logic [ADDR_W-1:0] i_ram_addr,
  input  logic [LINE_W-1:0] i_line_in,
  output logic              o_ddr_response,
  output logic [LINE_W-1:0] o_line_out,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [WORD_W-1:0] i_mem_rdata
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  state_t            r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic              w_buf_we;
  logic              w_accept;
  logic [ADDR_W-1:0] r_lat_base, w_base_src;
  logic [LINE_W-1:0] r_lat_line, w_line_src, w_asm_line;

  logic              r_ddr_response;
  logic [LINE_W-1:0] r_line_out;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;

  // Outputs are registered from next-state, so the request being accepted this
  // edge must be taken straight from the ports rather than the latches.
  assign w_accept   = (r_state == S_IDLE) && i_ram_en;
  assign w_base_src = w_accept ? (i_ram_addr & LINE_MASK) : r_lat_base;
  assign w_line_src = w_accept ? i_line_in : r_lat_line;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_buf_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ram_en) begin
          w_beat_nxt  = '0;
          w_state_nxt = i_ram_write ? S_WR : S_RD_REQ;
        end
      end
      S_WR: begin
        if (i_mem_gnt) begin
          if (r_beat == LAST_BEAT) w_state_nxt = S_RESP;
          else                     w_beat_nxt  = r_beat + 1'b1;
        end
      end
      S_RD_REQ: begin
        if (i_mem_gnt) w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_mem_rvalid) begin
          w_buf_we = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = S_RESP;
          end else begin
            w_beat_nxt  = r_beat + 1'b1;
            w_state_nxt = S_RD_REQ;
          end
        end
      end
      S_RESP:  w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ddr_response <= 1'b0;
      r_line_out     <= '0;
      r_busy         <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_lat_base     <= '0;
      r_lat_line     <= '0;
    end else begin
      r_mem_req      <= (w_state_nxt == S_WR) || (w_state_nxt == S_RD_REQ);
      r_mem_we       <= (w_state_nxt == S_WR);
      r_mem_addr     <= w_base_src | ADDR_W'({w_beat_nxt, 2'b00});
      r_mem_wdata    <= w_line_src[w_beat_nxt*WORD_W +: WORD_W];
      r_ddr_response <= (w_state_nxt == S_RESP);
      r_busy         <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_lat_base <= i_ram_addr & LINE_MASK;
        r_lat_line <= i_line_in;
      end
      if ((r_state == S_RD_WAIT) && (w_state_nxt == S_RESP)) r_line_out <= w_asm_line;
    end
  end

  ddr_line_responder_line_assembler u_line_asm (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_buf_we),
    .i_idx   (r_beat),
    .i_wdata (i_mem_rdata),
    .o_line  (w_asm_line)
  );

  assign o_ddr_response = r_ddr_response;
  assign o_line_out     = r_line_out;
  assign o_busy         = r_busy;
  assign o_mem_req      = r_mem_req;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_ddr_line_responder.sv
// Bench for ddr_line_responder: behavioural word-memory model, directed table,
// multi-cycle corner sequences and randomized line transactions.
module tb_ddr_line_responder;

  logic         clk = 1'b0;
  logic         i_rst, i_ram_en, i_ram_write;
  logic [31:0]  i_ram_addr;
  logic [255:0] i_line_in;
  logic         o_ddr_response, o_busy, o_mem_req, o_mem_we;
  logic [255:0] o_line_out;
  logic [31:0]  o_mem_addr, o_mem_wdata;
  logic         i_mem_gnt, i_mem_rvalid;
  logic [31:0]  i_mem_rdata;

  always #5 clk = ~clk;

  ddr_line_responder dut (
    .i_clk(clk), .i_rst(i_rst), .i_ram_en(i_ram_en), .i_ram_write(i_ram_write),
    .i_ram_addr(i_ram_addr), .i_line_in(i_line_in), .o_ddr_response(o_ddr_response),
    .o_line_out(o_line_out), .o_busy(o_busy), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e_cyc = 0;

  // memory model knobs and state
  int          gnt_mode = 0;   // 0: always grant, 1: random grant
  bit          rd_rand = 0;
  int          rd_dly_max = 1;
  logic [7:0]  rd_pat = 8'h00;
  bit          stray_en = 0;
  int          stall_beat = 0;
  int          stall_left = 0;
  bit          pend_valid = 0;
  int          pend_wait = 0;
  logic [31:0] pend_data = 0;
  int          outst_err = 0;

  logic [31:0]  acc_addr[$];
  bit           acc_we[$];
  logic [31:0]  acc_wd[$];
  logic [31:0]  rd_q[$];
  int           resp_t[$];
  logic [255:0] resp_line[$];
  logic [31:0]  stall_addr[$];
  logic [31:0]  stall_wd[$];
  logic [255:0] last_rd = '0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  pat;
    logic [31:0] exp_base;
    int          exp_lat;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pat_line(input logic [7:0] p);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'(p) + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] rd_q_line();
    logic [255:0] l = '0;
    for (int i = 0; i < 8 && i < rd_q.size(); i++) l[32*i +: 32] = rd_q[i];
    return l;
  endfunction

  task automatic clear_logs();
    acc_addr.delete(); acc_we.delete(); acc_wd.delete(); rd_q.delete();
    resp_t.delete(); resp_line.delete(); stall_addr.delete(); stall_wd.delete();
    outst_err = 0;
  endtask

  // One clock: memory model drives gnt/rvalid for the coming edge, then outputs are sampled.
  task automatic cycle();
    logic g;
    if (o_mem_req && !o_mem_we && pend_valid && !i_rst) outst_err++;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = $urandom;
    if (pend_valid) begin
      if (pend_wait == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = pend_data;
        pend_valid   = 0;
      end else begin
        pend_wait--;
      end
    end else if (stray_en) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hDEAD;
    end
    g = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (stall_left > 0 && o_mem_req && (o_mem_addr[4:2] == 3'(stall_beat))) begin
      g = 1'b0;
      stall_left--;
      stall_addr.push_back(o_mem_addr);
      stall_wd.push_back(o_mem_wdata);
    end
    i_mem_gnt = g;
    if (i_rst) begin
      pend_valid = 0;
    end else if (o_mem_req && g) begin
      acc_addr.push_back(o_mem_addr);
      acc_we.push_back(o_mem_we);
      acc_wd.push_back(o_mem_wdata);
      if (!o_mem_we) begin
        pend_valid = 1;
        pend_wait  = $urandom_range(0, rd_dly_max - 1);
        pend_data  = rd_rand ? $urandom : (32'(rd_pat) + 32'(o_mem_addr[4:2]));
        rd_q.push_back(pend_data);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (o_ddr_response) begin
      resp_t.push_back(cyc);
      resp_line.push_back(o_line_out);
    end
  endtask

  task automatic wait_resp(input int n, input int budget);
    int k = 0;
    while (resp_t.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("response timeout", 256'(resp_t.size() >= n), 256'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (o_busy && k < 20) begin
      cycle();
      k++;
    end
    chk("idle timeout", 256'(o_busy), 256'(0));
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] line);
    clear_logs();
    i_ram_en = 1'b1; i_ram_write = wr; i_ram_addr = addr; i_line_in = line;
    cycle();
    e_cyc = cyc;
    i_ram_en = 1'b0; i_ram_write = 1'($urandom); i_ram_addr = $urandom; i_line_in = rand_line();
    wait_resp(1, 400);
    wait_idle();
  endtask

  task automatic check_txn(input string nm, input bit wr, input logic [31:0] base,
                           input logic [255:0] wline, input logic [255:0] exp_line,
                           input int exp_lat);
    chk({nm, " nresp"}, 256'(resp_t.size()), 256'(1));
    chk({nm, " naccess"}, 256'(acc_addr.size()), 256'(8));
    for (int i = 0; i < 8 && i < acc_addr.size(); i++) begin
      chk({nm, " addr"}, 256'(acc_addr[i]), 256'(base + 32'(4 * i)));
      chk({nm, " we"}, 256'(acc_we[i]), 256'(wr));
      if (wr) chk({nm, " wdata"}, 256'(acc_wd[i]), 256'(wline[32*i +: 32]));
    end
    if (resp_t.size() > 0) begin
      chk({nm, " line at resp"}, resp_line[0], exp_line);
      if (exp_lat > 0) chk({nm, " latency"}, 256'(resp_t[0] - e_cyc + 1), 256'(exp_lat));
    end
    chk({nm, " outstanding"}, 256'(outst_err), 256'(0));
    chk({nm, " line held"}, o_line_out, exp_line);
    if (!wr) last_rd = exp_line;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l;
    int k;
    i_rst = 1'b1; i_ram_en = 1'b0; i_ram_write = 1'b0; i_ram_addr = '0; i_line_in = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    cycle(); cycle();
    chk("rst busy", 256'(o_busy), 256'(0));
    chk("rst mem_req", 256'(o_mem_req), 256'(0));
    chk("rst mem_we", 256'(o_mem_we), 256'(0));
    chk("rst mem_addr", 256'(o_mem_addr), 256'(0));
    chk("rst mem_wdata", 256'(o_mem_wdata), 256'(0));
    chk("rst response", 256'(o_ddr_response), 256'(0));
    chk("rst line_out", o_line_out, 256'(0));
    i_rst = 1'b0;
    cycle();

    // latency counts the cycle that ends at edge E+n with ram_en sampled at edge E
    vecs[0] = '{wr: 1'b0, addr: 32'h0000_1234, pat: 8'h10, exp_base: 32'h0000_1220, exp_lat: 17};
    vecs[1] = '{wr: 1'b1, addr: 32'h0000_8040, pat: 8'hA0, exp_base: 32'h0000_8040, exp_lat: 9};
    vecs[2] = '{wr: 1'b0, addr: 32'hFFFF_FFFF, pat: 8'h55, exp_base: 32'hFFFF_FFE0, exp_lat: 17};
    vecs[3] = '{wr: 1'b1, addr: 32'h0000_001F, pat: 8'hF0, exp_base: 32'h0000_0000, exp_lat: 9};
    vecs[4] = '{wr: 1'b0, addr: 32'h8000_0020, pat: 8'h30, exp_base: 32'h8000_0020, exp_lat: 17};
    gnt_mode = 0; rd_rand = 0; rd_dly_max = 1;
    for (int v = 0; v < 5; v++) begin
      rd_pat = vecs[v].pat;
      run_txn(vecs[v].wr, vecs[v].addr, pat_line(vecs[v].pat));
      check_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].exp_base, pat_line(vecs[v].pat),
                vecs[v].wr ? last_rd : pat_line(vecs[v].pat), vecs[v].exp_lat);
    end

    // stray read data while idle and during a write-back
    stray_en = 1;
    for (int i = 0; i < 6; i++) cycle();
    chk("stray idle line_out", o_line_out, last_rd);
    l = rand_line();
    run_txn(1'b1, 32'h0000_C000, l);
    check_txn("stray wr", 1'b1, 32'h0000_C000, l, last_rd, 9);
    stray_en = 0;

    // grant withheld three cycles on beat 4
    l = rand_line();
    stall_beat = 4; stall_left = 3;
    run_txn(1'b1, 32'h0000_9100, l);
    check_txn("stall", 1'b1, 32'h0000_9100, l, last_rd, 12);
    chk("stall cycles", 256'(stall_addr.size()), 256'(3));
    for (int i = 0; i < stall_addr.size(); i++) begin
      chk("stall addr stable", 256'(stall_addr[i]), 256'(32'h0000_9110));
      chk("stall wdata stable", 256'(stall_wd[i]), 256'(l[32*4 +: 32]));
    end
    stall_left = 0;

    // write-back then load with ram_en held across RESP/GAP
    clear_logs();
    rd_pat = 8'h40;
    l = rand_line();
    i_ram_en = 1'b1; i_ram_write = 1'b1; i_ram_addr = 32'h0000_2000; i_line_in = l;
    cycle();
    e_cyc = cyc;
    i_ram_write = 1'b0; i_ram_addr = 32'h0000_3000; i_line_in = rand_line();
    wait_resp(2, 200);
    i_ram_en = 1'b0;
    wait_idle();
    chk("b2b nresp", 256'(resp_t.size()), 256'(2));
    chk("b2b naccess", 256'(acc_addr.size()), 256'(16));
    if (resp_t.size() >= 2) begin
      chk("b2b wr latency", 256'(resp_t[0] - e_cyc + 1), 256'(9));
      // RESP + GAP + IDLE + 16 read cycles
      chk("b2b separation", 256'(resp_t[1] - resp_t[0]), 256'(19));
      chk("b2b wr line_out", resp_line[0], last_rd);
      chk("b2b rd line_out", resp_line[1], pat_line(8'h40));
    end
    for (int i = 0; i < 16 && i < acc_addr.size(); i++) begin
      chk("b2b addr", 256'(acc_addr[i]),
          256'((i < 8) ? 32'h0000_2000 + 32'(4 * i) : 32'h0000_3000 + 32'(4 * (i - 8))));
      chk("b2b we", 256'(acc_we[i]), 256'(i < 8));
      if (i < 8) chk("b2b wdata", 256'(acc_wd[i]), 256'(l[32*i +: 32]));
    end
    last_rd = pat_line(8'h40);

    // reset in the middle of a load
    clear_logs();
    rd_pat = 8'h70;
    i_ram_en = 1'b1; i_ram_write = 1'b0; i_ram_addr = 32'h0000_5000;
    cycle();
    i_ram_en = 1'b0;
    k = 0;
    while (!(o_mem_req && o_mem_addr[4:2] == 3'd3) && k < 100) begin
      cycle();
      k++;
    end
    chk("rst reach beat3 addr", 256'(o_mem_addr), 256'(32'h0000_500C));
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    chk("midrst mem_req", 256'(o_mem_req), 256'(0));
    chk("midrst busy", 256'(o_busy), 256'(0));
    chk("midrst response", 256'(o_ddr_response), 256'(0));
    chk("midrst line_out", o_line_out, 256'(0));
    for (int i = 0; i < 3; i++) cycle();
    chk("midrst no response", 256'(resp_t.size()), 256'(0));
    last_rd = '0;
    rd_pat = 8'h90;
    run_txn(1'b0, 32'h0000_6000, rand_line());
    check_txn("after rst", 1'b0, 32'h0000_6000, '0, pat_line(8'h90), 17);

    // randomized traffic with random grant and read latency
    gnt_mode = 1; rd_rand = 1; rd_dly_max = 3;
    for (int t = 0; t < 24; t++) begin
      bit          wr;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      l  = rand_line();
      run_txn(wr, a, l);
      check_txn($sformatf("rand%0d", t), wr, a & ~32'h1F, l, wr ? last_rd : rd_q_line(), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
